// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared definitions for the vending-machine controller:
//                FSM state encoding, coin values and a coin-sum helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // Controller states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    // Coin denominations in cents
    localparam logic [7:0] c_coin5_val  = 8'd5;
    localparam logic [7:0] c_coin10_val = 8'd10;
    localparam logic [7:0] c_coin25_val = 8'd25;

    // Total value of all coins presented in one cycle (at most 40 cents)
    function automatic logic [7:0] coin_sum(input logic c5, input logic c10, input logic c25);
        return ({8{c5}}  & c_coin5_val)
             + ({8{c10}} & c_coin10_val)
             + ({8{c25}} & c_coin25_val);
    endfunction

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : vend_fsm
//  Description : Coin-operated vending controller. Accumulates credit from
//                5/10/25-cent coins, vends a product at PRICE and returns the
//                remaining credit as a train of 5-cent change pulses spaced
//                GAP idle cycles apart.
//  Ports       : clk         - rising-edge clock
//                reset       - synchronous, active-low reset
//                coin5/10/25 - single-cycle coin pulses
//                buy, cancel - single-cycle request pulses
//                credit      - current credit in cents (registered)
//                vend        - one-cycle product release pulse
//                change5     - one-cycle pulse, eject one 5-cent coin
//                coin_reject - one-cycle pulse, physically return coin(s)
//                busy        - high while vending or paying out change
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_fsm
    import vend_pkg::*;
#(
    parameter int unsigned PRICE      = 65,
    parameter int unsigned MAX_CREDIT = 200,
    parameter int unsigned GAP        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       coin25,
    input  logic       buy,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       vend,
    output logic       change5,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned      c_gap_w      = $clog2(GAP + 1);
    localparam logic [c_gap_w-1:0] c_gap      = c_gap_w'(GAP);
    localparam logic [7:0]       c_price      = 8'(PRICE);
    localparam logic [8:0]       c_max_credit = 9'(MAX_CREDIT);

    state_t             r_state;
    logic [7:0]         r_credit;
    logic               r_vend;
    logic               r_change5;
    logic               r_coin_reject;
    logic               r_busy;
    logic [c_gap_w-1:0] r_gap_cnt;

    logic [7:0] w_sum;
    logic [8:0] w_total;
    logic       w_any_coin;
    logic       w_over_limit;
    logic [7:0] w_credit_upd;

    // Coins are accounted before buy/cancel are evaluated, so the decision in
    // IDLE uses the post-coin credit. The 9-bit total catches the carry when
    // credit is near 255.
    assign w_sum        = coin_sum(coin5, coin10, coin25);
    assign w_any_coin   = coin5 | coin10 | coin25;
    assign w_total      = {1'b0, r_credit} + {1'b0, w_sum};
    assign w_over_limit = (w_total > c_max_credit);
    assign w_credit_upd = w_over_limit ? r_credit : w_total[7:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_vend        <= 1'b0;
            r_change5     <= 1'b0;
            r_coin_reject <= 1'b0;
            r_busy        <= 1'b0;
            r_gap_cnt     <= '0;
        end else begin
            r_vend        <= 1'b0;
            r_change5     <= 1'b0;
            r_coin_reject <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // One reject pulse covers every coin of an overflowing cycle
                    r_coin_reject <= w_over_limit & w_any_coin;
                    r_credit      <= w_credit_upd;
                    // cancel takes priority over buy
                    if (cancel && (w_credit_upd != 8'd0)) begin
                        r_state   <= ST_CHANGE;
                        r_busy    <= 1'b1;
                        r_gap_cnt <= '0;
                    end else if (buy && (w_credit_upd >= c_price)) begin
                        r_state  <= ST_VEND;
                        r_credit <= w_credit_upd - c_price;
                        r_vend   <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end

                ST_VEND: begin
                    r_coin_reject <= w_any_coin;
                    if (r_credit != 8'd0) begin
                        r_state   <= ST_CHANGE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_CHANGE: begin
                    r_coin_reject <= w_any_coin;
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end else if (r_credit >= c_coin5_val) begin
                        // Credit is always a multiple of 5, so this never underflows
                        r_change5 <= 1'b1;
                        r_credit  <= r_credit - c_coin5_val;
                        r_gap_cnt <= c_gap;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign credit      = r_credit;
    assign vend        = r_vend;
    assign change5     = r_change5;
    assign coin_reject = r_coin_reject;
    assign busy        = r_busy;

endmodule : vend_fsm
`default_nettype wire

// File: tb/tb_vend_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_fsm
//  Description : Directed self-checking bench for vend_fsm with default
//                parameters (PRICE 65, MAX_CREDIT 200, GAP 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin5, coin10, coin25, buy, cancel;
    logic [7:0] credit;
    logic       vend, change5, coin_reject, busy;

    int checks = 0;
    int errors = 0;

    int  n_ch, n_vend, first_cyc, last_cyc;
    bit  timed_out;

    vend_fsm #(.PRICE(65), .MAX_CREDIT(200), .GAP(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .coin5      (coin5),
        .coin10     (coin10),
        .coin25     (coin25),
        .buy        (buy),
        .cancel     (cancel),
        .credit     (credit),
        .vend       (vend),
        .change5    (change5),
        .coin_reject(coin_reject),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs set before the call are sampled at this edge
    // and outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        coin5 = 0; coin10 = 0; coin25 = 0; buy = 0; cancel = 0;
    endtask

    // Step until busy drops, counting change5/vend pulses and the cycles of
    // the first and last change5.
    task automatic drain(input int max_cyc, output int nc, output int nv,
                         output int fc, output int lc, output bit to);
        nc = 0; nv = 0; fc = -1; lc = -1; to = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (change5) begin
                nc++;
                if (fc < 0) fc = i;
                lc = i;
            end
            if (vend) nv++;
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        step();
        step();
        chk("reset_credit",      32'(credit),      0);
        chk("reset_vend",        32'(vend),        0);
        chk("reset_change5",     32'(change5),     0);
        chk("reset_coin_reject", 32'(coin_reject), 0);
        chk("reset_busy",        32'(busy),        0);
        reset = 1'b1;

        // Three quarters then buy: 75 -> 10, one vend, two change pulses
        for (int i = 0; i < 3; i++) begin
            coin25 = 1; step(); coin25 = 0;
        end
        chk("q3_credit", 32'(credit), 75);
        buy = 1; step(); buy = 0;
        chk("buy_vend",   32'(vend),   1);
        chk("buy_credit", 32'(credit), 10);
        chk("buy_busy",   32'(busy),   1);
        drain(60, n_ch, n_vend, first_cyc, last_cyc, timed_out);
        chk("q3_timeout", 32'(timed_out), 0);
        chk("q3_nchange", 32'(n_ch), 2);
        chk("q3_spacing", 32'(last_cyc - first_cyc), 5);
        chk("q3_novend",  32'(n_vend), 0);
        chk("q3_credit0", 32'(credit), 0);

        // Idle-state requests with zero credit are ignored
        cancel = 1; step(); cancel = 0;
        chk("cancel0_busy", 32'(busy), 0);
        buy = 1; step(); buy = 0;
        chk("buy0_vend", 32'(vend), 0);

        // All three coins in one cycle
        coin5 = 1; coin10 = 1; coin25 = 1; step(); clear_inputs();
        chk("sim_credit", 32'(credit), 40);
        chk("sim_reject", 32'(coin_reject), 0);

        // Build to 190, overflow reject, then exactly the ceiling
        for (int i = 0; i < 6; i++) begin
            coin25 = 1; step(); coin25 = 0;
        end
        chk("c190_credit", 32'(credit), 190);
        coin25 = 1; step(); coin25 = 0;
        chk("ovf_reject", 32'(coin_reject), 1);
        chk("ovf_credit", 32'(credit), 190);
        coin10 = 1; step(); coin10 = 0;
        chk("ceil_reject", 32'(coin_reject), 0);
        chk("ceil_credit", 32'(credit), 200);

        // Refund the full ceiling: 40 change pulses
        cancel = 1; step(); cancel = 0;
        chk("refund_busy", 32'(busy), 1);
        drain(400, n_ch, n_vend, first_cyc, last_cyc, timed_out);
        chk("refund_timeout", 32'(timed_out), 0);
        chk("refund_nchange", 32'(n_ch), 40);
        chk("refund_credit",  32'(credit), 0);

        // Credit 30: buy ignored, buy+cancel refunds without vending
        coin25 = 1; coin5 = 1; step(); clear_inputs();
        chk("c30_credit", 32'(credit), 30);
        buy = 1; step(); buy = 0;
        chk("lowbuy_vend",   32'(vend),   0);
        chk("lowbuy_busy",   32'(busy),   0);
        chk("lowbuy_credit", 32'(credit), 30);
        buy = 1; cancel = 1; step(); clear_inputs();
        chk("bc_vend", 32'(vend), 0);
        chk("bc_busy", 32'(busy), 1);
        drain(100, n_ch, n_vend, first_cyc, last_cyc, timed_out);
        chk("bc_timeout", 32'(timed_out), 0);
        chk("bc_nchange", 32'(n_ch), 6);
        chk("bc_nvend",   32'(n_vend), 0);
        chk("bc_credit",  32'(credit), 0);

        // Exact price: vend, coin during VEND rejected, straight back to IDLE
        coin5 = 1; coin10 = 1; coin25 = 1; step(); clear_inputs();
        coin25 = 1; step(); coin25 = 0;
        chk("c65_credit", 32'(credit), 65);
        buy = 1; step(); buy = 0;
        chk("exact_vend",   32'(vend),   1);
        chk("exact_credit", 32'(credit), 0);
        coin10 = 1; step(); coin10 = 0;
        chk("vendcoin_reject", 32'(coin_reject), 1);
        chk("vendcoin_credit", 32'(credit), 0);
        chk("vendcoin_busy",   32'(busy), 0);
        n_ch = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (change5) n_ch++;
        end
        chk("exact_nochange", 32'(n_ch), 0);

        // Coin together with buy: 50 + 25 = 75 -> vend, 10 left
        coin25 = 1; step(); step(); coin25 = 0;
        chk("c50_credit", 32'(credit), 50);
        coin25 = 1; buy = 1; step(); clear_inputs();
        chk("coinbuy_vend",   32'(vend),   1);
        chk("coinbuy_credit", 32'(credit), 10);
        drain(60, n_ch, n_vend, first_cyc, last_cyc, timed_out);
        chk("coinbuy_nchange", 32'(n_ch), 2);

        // Reset during CHANGE after the second change pulse
        coin25 = 1; step(); step(); coin25 = 0;
        cancel = 1; step(); cancel = 0;
        n_ch = 0;
        for (int i = 0; i < 40 && n_ch < 2; i++) begin
            step();
            if (change5) n_ch++;
        end
        chk("rstmid_reach2",  32'(n_ch), 2);
        chk("rstmid_precred", 32'(credit), 40);
        reset = 1'b0; step(); reset = 1'b1;
        chk("rstmid_credit",  32'(credit), 0);
        chk("rstmid_change5", 32'(change5), 0);
        chk("rstmid_busy",    32'(busy), 0);
        chk("rstmid_vend",    32'(vend), 0);
        n_ch = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (change5) n_ch++;
        end
        chk("rstmid_nochange", 32'(n_ch), 0);
        chk("rstmid_credit_after", 32'(credit), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vend_fsm
`default_nettype wire

// File: doc/vend_fsm.md
VEND_FSM -- requirements
Module: vend_fsm

Interface
REQ-001 SHALL have parameter PRICE, default 65, product price in cents; multiple of 5, range 5..MAX_CREDIT.
REQ-002 SHALL have parameter MAX_CREDIT, default 200, credit ceiling in cents; multiple of 5, at most 255.
REQ-003 SHALL have parameter GAP, default 4, idle cycles between change pulses; GAP >= 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low; 0 at a rising clk edge resets the block.
REQ-006 SHALL have port coin5, input, 1 bit: single-cycle debounced pulse, one 5-cent coin.
REQ-007 SHALL have port coin10, input, 1 bit: single-cycle debounced pulse, one 10-cent coin.
REQ-008 SHALL have port coin25, input, 1 bit: single-cycle debounced pulse, one 25-cent coin.
REQ-009 SHALL have port buy, input, 1 bit: single-cycle debounced pulse, purchase request.
REQ-010 SHALL have port cancel, input, 1 bit: single-cycle debounced pulse, refund request.
REQ-011 SHALL have port credit, output, 8 bits: current credit in cents, registered.
REQ-012 SHALL have port vend, output, 1 bit: one-cycle pulse, release product.
REQ-013 SHALL have port change5, output, 1 bit: one-cycle pulse, eject one 5-cent coin.
REQ-014 SHALL have port coin_reject, output, 1 bit: one-cycle pulse, return the inserted coin(s) physically.
REQ-015 SHALL have port busy, output, 1 bit: high in VEND and CHANGE states.

Function
REQ-016 SHALL implement states IDLE, VEND, CHANGE; all outputs registered, one-cycle latency from input sample.
REQ-017 In IDLE, each cycle SHALL compute sum = 5*coin5 + 10*coin10 + 25*coin25, allowing simultaneous coins.
REQ-018 In IDLE, if credit + sum <= MAX_CREDIT, SHALL set credit to credit + sum, computed in a 9-bit intermediate.
REQ-019 In IDLE, if credit + sum > MAX_CREDIT, SHALL leave credit unchanged and pulse coin_reject once for all coins that cycle.
REQ-020 In IDLE, buy with credit >= PRICE SHALL move to VEND and subtract PRICE from credit.
REQ-021 In IDLE, buy with credit < PRICE SHALL be ignored; no output change.
REQ-022 In IDLE, cancel with credit > 0 SHALL move to CHANGE; cancel with credit == 0 SHALL be ignored.
REQ-023 Simultaneous buy and cancel SHALL be resolved in favour of cancel.
REQ-024 Coins arriving with a buy or cancel in the same IDLE cycle SHALL be added or rejected first; the decision then uses the updated credit.
REQ-025 VEND SHALL assert vend for exactly one cycle, then go to CHANGE if credit > 0, else to IDLE.
REQ-026 CHANGE SHALL pulse change5 and decrement credit by 5, then wait GAP cycles; it SHALL repeat until credit == 0, then go to IDLE.
REQ-027 In VEND or CHANGE, any coin pulse SHALL produce a coin_reject pulse; buy and cancel SHALL be ignored.
REQ-028 change5 SHALL never fire when credit == 0; credit SHALL never underflow.

Reset
REQ-029 When reset == 0 at a clk edge, SHALL set state IDLE, credit 0, vend 0, change5 0, coin_reject 0, busy 0, and clear the gap counter.
REQ-030 Reset mid-VEND or mid-CHANGE SHALL abort immediately with no further pulses; the residual credit is forfeited.

Structure
REQ-031 State encoding and coin values (5, 10, 25) SHALL reside in shared package vend_pkg.
REQ-032 SHALL be a single module with no sub-modules; the gap counter is a local register of width clog2(GAP+1).

Verification
REQ-033 Reset, then coin25 x3, then buy -> credit 75, then 10; vend pulse; two change5 pulses 5 cycles apart; credit 0; IDLE.
REQ-034 coin5, coin10 and coin25 in the same cycle from credit 0 -> credit 40 one cycle later; no coin_reject.
REQ-035 Credit 190, then coin25 -> coin_reject pulse; credit stays 190.
REQ-036 Credit 30, then buy -> ignored; then buy and cancel together -> six change5 pulses and no vend.
REQ-037 Credit 65, then buy -> vend; coin10 during VEND -> coin_reject; credit 0; return to IDLE with no change5.
REQ-038 Reset low during CHANGE after the 2nd change5 -> outputs 0 and credit 0 the next cycle; no further change5.
